// File: rtl/adder_arbiter_if.sv
// Request/response bundle between two requesters, the result consumer and adder_arbiter.
// slave = arbiter side, master = requester/consumer side.
interface adder_arbiter_if;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req_a0;
  logic [31:0] req_b0;
  logic [31:0] req_a1;
  logic [31:0] req_b1;
  logic [1:0]  req_sub;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [31:0] rsp_sum;
  logic        rsp_carry;
  logic        rsp_ovf;

  modport slave (
    input  req_valid, req_a0, req_b0, req_a1, req_b1, req_sub, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_carry, rsp_ovf
  );

  modport master (
    output req_valid, req_a0, req_b0, req_a1, req_b1, req_sub, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_carry, rsp_ovf
  );
endinterface

// File: rtl/adder_arbiter.sv
// Two-port round-robin arbiter and two-stage sequencer in front of the shared 32-bit adder.
// Define ADDER_ARB_FIXED_PRIO_EN for fixed priority (port 0 wins ties, no last-winner register).

// 32-bit carry-select adder: low half ripples, high half is precomputed for both carries.
module adder (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        carry_in_i,
  output logic [31:0] sum_o,
  output logic        carry_out_o,
  output logic        carry_30_o
);
  logic [16:0] lo_sum;
  logic [15:0] hi_sum0;
  logic [15:0] hi_sum1;
  logic [14:0] hi_bits;
  logic        c30;

  assign lo_sum  = {1'b0, a_i[15:0]} + {1'b0, b_i[15:0]} + {16'd0, carry_in_i};
  // Bits 30:16 only, so the carry into the MSB is visible for the overflow flag.
  assign hi_sum0 = {1'b0, a_i[30:16]} + {1'b0, b_i[30:16]};
  assign hi_sum1 = {1'b0, a_i[30:16]} + {1'b0, b_i[30:16]} + 16'd1;

  assign c30     = lo_sum[16] ? hi_sum1[15]   : hi_sum0[15];
  assign hi_bits = lo_sum[16] ? hi_sum1[14:0] : hi_sum0[14:0];

  assign sum_o       = {a_i[31] ^ b_i[31] ^ c30, hi_bits, lo_sum[15:0]};
  assign carry_out_o = (a_i[31] & b_i[31]) | (a_i[31] & c30) | (b_i[31] & c30);
  assign carry_30_o  = c30;
endmodule

module adder_arbiter (
  input  logic            clock,
  input  logic            reset_n,
  adder_arbiter_if.slave  bus
);
  // Stage A: accepted operands, frozen until they move into R.
  logic        a_v_q, a_v_d;
  logic [31:0] a_a_q, a_b_q;
  logic        a_sub_q, a_id_q;

  // Stage R: registered result driving rsp_* directly.
  logic        r_v_q, r_v_d;
  logic [31:0] r_sum_q;
  logic        r_carry_q, r_ovf_q, r_id_q;

  logic        r_can, a_can, r_load;
  logic [1:0]  grant;
  logic [1:0]  ready;
  logic        xfer;
  logic        win_id;
  logic [31:0] win_a, win_b;
  logic        win_sub;

  logic [31:0] add_b, add_sum;
  logic        add_cout, add_c30;

  assign r_can  = !r_v_q | bus.rsp_ready;
  assign a_can  = !a_v_q | r_can;
  assign r_load = a_v_q & r_can;

`ifdef ADDER_ARB_FIXED_PRIO_EN
  always_comb begin
    if (bus.req_valid[0])      grant = 2'b01;
    else if (bus.req_valid[1]) grant = 2'b10;
    else                       grant = 2'b00;
  end
`else
  logic last_q, last_d;

  always_comb begin
    unique case (bus.req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_q ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // The tie-break pointer only moves when a request is actually taken.
  assign last_d = xfer ? win_id : last_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) last_q <= 1'b1;
    else          last_q <= last_d;
  end
`endif

  // Nothing is offered while reset is asserted, even though the stages read empty.
  assign ready         = grant & {2{a_can & reset_n}};
  assign bus.req_ready = ready;
  assign xfer          = |(bus.req_valid & ready);

  assign win_id  = ready[1];
  assign win_a   = win_id ? bus.req_a1 : bus.req_a0;
  assign win_b   = win_id ? bus.req_b1 : bus.req_b0;
  assign win_sub = bus.req_sub[win_id];

  always_comb begin
    // NOTE: every combinationally assigned variable gets a value on every path,
    // here by defaulting first, so no latch is inferred.
    a_v_d = a_v_q;
    if (xfer)       a_v_d = 1'b1;
    else if (r_can) a_v_d = 1'b0;
  end

  assign r_v_d = r_can ? a_v_q : r_v_q;

  always_ff @(posedge clock or negedge reset_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (!reset_n) begin
      a_v_q <= 1'b0;
      r_v_q <= 1'b0;
    end else begin
      a_v_q <= a_v_d;
      r_v_q <= r_v_d;
    end
  end

  // NOTE: operand registers carry no reset; they are only observed while a_v_q is set,
  // which keeps the reset tree off the wide datapath.
  always_ff @(posedge clock) begin
    if (xfer) begin
      a_a_q   <= win_a;
      a_b_q   <= win_b;
      a_sub_q <= win_sub;
      a_id_q  <= win_id;
    end
  end

  assign add_b = a_sub_q ? ~a_b_q : a_b_q;

  adder u_adder (
    .a_i         (a_a_q),
    .b_i         (add_b),
    .carry_in_i  (a_sub_q),
    .sum_o       (add_sum),
    .carry_out_o (add_cout),
    .carry_30_o  (add_c30)
  );

  // Result registers are reset because they are visible on rsp_* at all times.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sum_q   <= 32'd0;
      r_carry_q <= 1'b0;
      r_ovf_q   <= 1'b0;
      r_id_q    <= 1'b0;
    end else if (r_load) begin
      r_sum_q   <= add_sum;
      r_carry_q <= add_cout;
      r_ovf_q   <= add_cout ^ add_c30;
      r_id_q    <= a_id_q;
    end
  end

  assign bus.rsp_valid = r_v_q;
  assign bus.rsp_id    = r_id_q;
  assign bus.rsp_sum   = r_sum_q;
  assign bus.rsp_carry = r_carry_q;
  assign bus.rsp_ovf   = r_ovf_q;
endmodule

// File: doc/adder_arbiter.md
# adder_arbiter

Two-port arbiter and sequencer for the shared 32-bit carry-select `adder`. It accepts add/subtract requests from two requesters over valid/ready handshakes, grants the single adder round-robin, and returns a registered result tagged with the winning port. The result carries sum, carry and signed-overflow flags. It sits between the ALU issue logic and the one `adder` instance, so no requester drives the adder directly.

## Interface
Parameters: none (width fixed at 32).
- `clock`  in  1  sole clock, all state on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  2  per-port request valid (bit i = port i)
- `req_ready`  out  2  per-port accept; transfer when `req_valid[i] & req_ready[i]`
- `req_a0`, `req_b0`  in  32  port 0 operands
- `req_a1`, `req_b1`  in  32  port 1 operands
- `req_sub`  in  2  per-port op: 0 = a+b, 1 = a−b
- `rsp_valid`  out  1  result valid
- `rsp_ready`  in  1  consumer accepts result
- `rsp_id`  out  1  port that issued the result
- `rsp_sum`  out  32  result
- `rsp_carry`  out  1  adder carry_out (for subtract, 1 = no borrow)
- `rsp_ovf`  out  1  signed overflow = carry_out XOR carry_30

## Operation
- Internal `adder` instance: a = stage-A operand, b = `sub ? ~b : b`, carry_in = `sub`.
- Two pipeline stages: A (operand register: a, b, sub, id, `a_v`) and R (result register: sum, carry, ovf, id, `r_v`); outputs `rsp_*` driven straight from R.
- Stage R loads when `r_can = !r_v | rsp_ready`; it takes A when `a_v & r_can`, else clears `r_v` when drained.
- Stage A loads when `a_can = !a_v | (a_v & r_can)`; `req_ready[i] = grant[i] & a_can`.
- Grant (round-robin): one requester valid → it wins; both valid → the port ≠ `last`; `last` updates to the winner only on an actual transfer.
- `req_ready` is combinational from `req_valid`, `last`, `a_v`, `r_v`, `rsp_ready`; at most one bit set.
- Requester may hold or change operands until transfer; once accepted, operands are frozen in A.
- Results return in acceptance order; no reordering.

## Timing
- Reset (async assert, sync use on release): `a_v=0`, `r_v=0`, `rsp_valid=0`, `rsp_id=0`, `rsp_sum=0`, `rsp_carry=0`, `rsp_ovf=0`, `last=1` (port 0 wins first tie), `req_ready=2'b00` while `reset_n=0`.
- Latency: transfer at edge N → `rsp_valid=1` after edge N+1 (2 cycles), with `rsp_ready` held high.
- Throughput: 1 result/cycle with `rsp_ready=1`; both ports valid continuously → strict alternation 0,1,0,1…
- Backpressure: `rsp_ready=0` with `r_v=1` holds R stable; A still fills once, then `req_ready=0` until R drains. Max 2 requests in flight.
- Simultaneous drain and fill of R/A in one cycle is allowed (no bubble).
- Reset mid-operation discards A and R contents; no result emitted for in-flight requests.
- Wrap-around: 32-bit modulo arithmetic; `0xFFFFFFFF+1 = 0`, carry=1, ovf=0.

## Configuration
- `ADDER_ARB_FIXED_PRIO_EN`: defined → fixed priority, port 0 always wins when both valid; `last` register is removed. Undefined (default) → round-robin as above.

## Test plan
- Reset: hold `reset_n=0` with both `req_valid=1` → `req_ready=00`, `rsp_valid=0`, all `rsp_*` zero; release → first grant to port 0.
- Single add: port 0, a=0x7FFFFFFF, b=1, sub=0 → 2 cycles later `rsp_sum=0x80000000`, carry=0, ovf=1, id=0.
- Subtract: port 1, a=5, b=7, sub=1 → `rsp_sum=0xFFFFFFFE`, carry=0, ovf=0, id=1; a=7,b=5 → sum=2, carry=1.
- Fairness: both ports valid for 8 cycles, `rsp_ready=1` → ids 0,1,0,1,0,1,0,1, one result per cycle.
- Backpressure: `rsp_ready=0` for 5 cycles during a stream → exactly 2 accepted, `rsp_*` stable, then `rsp_ready=1` drains in order with no loss or duplicate.
- Mid-flight reset: assert `reset_n=0` with A and R full → `rsp_valid` drops immediately, no stale result after release.
